ram_dp_be: RTL and testbench

Single-clock true dual-port RAM for the MSP430 memory subsystem, generalised in width, depth and read latency.
- Adds per-byte write enables, per-port request enable and registered read-valid.
- Adds deterministic same-address collision arbitration with a flag.
- Adds a post-reset hardware clear engine, since an asynchronous reset cannot clear the storage array.
- Holds data/program RAM shared between the CPU port (A) and a DMA/debug port (B).

---
 rtl/ram_dp_be.sv | 228 ++++++++++++++++++++++
 tb/tb_ram_dp_be.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_be.sv
// rtl/ram_dp_be.sv - single-clock true dual-port RAM with byte enables, clear engine and collision flag
//
// Purpose: data/program RAM shared by the CPU port (A) and a DMA/debug port (B).
// After reset, a clear engine writes CLEAR_VALUE to every word. The ports are
// ignored while init_busy is high. Reads are read-first. Port A wins byte-wise
// write conflicts. A same-address access with at least one write pulses
// collision on the following cycle.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   init_busy                high while the clear engine runs
//   a_en/a_we/a_addr/a_din   port A request (a_we==0 means read)
//   a_dout/a_valid           port A read data and completion pulse
//   b_*                      same as A, for port B
//   collision                registered same-address conflict pulse
//   a_perr/b_perr            parity error pulse with x_valid (parity build only)
//   a_perr_inject/b_perr_inject  invert stored parity on write (parity build only)
//
// Optional feature macro: RAM_DP_BE_PARITY_EN (even parity per data byte).

module ram_dp_be #(
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    ADDR_WIDTH   = 10,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    init_busy,
    input  logic                    a_en,
    input  logic [DATA_WIDTH/8-1:0] a_we,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_din,
    output logic [DATA_WIDTH-1:0]   a_dout,
    output logic                    a_valid,
    input  logic                    b_en,
    input  logic [DATA_WIDTH/8-1:0] b_we,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    input  logic [DATA_WIDTH-1:0]   b_din,
    output logic [DATA_WIDTH-1:0]   b_dout,
    output logic                    b_valid,
`ifdef RAM_DP_BE_PARITY_EN
    input  logic                    a_perr_inject,
    input  logic                    b_perr_inject,
    output logic                    a_perr,
    output logic                    b_perr,
`endif
    output logic                    collision
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("ram_dp_be: READ_LATENCY must be 1 or 2");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef RAM_DP_BE_PARITY_EN
    logic [NB-1:0] mem_par [DEPTH];

    function automatic logic [NB-1:0] byte_par(input logic [DATA_WIDTH-1:0] d);
        logic [NB-1:0] r;
        for (int i = 0; i < NB; i++) r[i] = ^d[i*8 +: 8];
        return r;
    endfunction
`endif

    // ---------------- clear engine ----------------
    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_ptr <= clr_ptr + ADDR_WIDTH'(1);
            if (clr_ptr == {ADDR_WIDTH{1'b1}}) state <= ST_READY;
        end
    end

    assign init_busy = (state == ST_CLEAR);

    // ---------------- per-port request decode ----------------
    logic [1:0]            p_en;
    logic [NB-1:0]         p_we    [2];
    logic [ADDR_WIDTH-1:0] p_addr  [2];
    logic [DATA_WIDTH-1:0] p_din   [2];
    logic [DATA_WIDTH-1:0] p_dout  [2];
    logic [1:0]            p_valid;
    logic [NB-1:0]         wmask   [2];
    logic [1:0]            rd_req;

    assign p_en      = {b_en, a_en};
    assign p_we[0]   = a_we;
    assign p_we[1]   = b_we;
    assign p_addr[0] = a_addr;
    assign p_addr[1] = b_addr;
    assign p_din[0]  = a_din;
    assign p_din[1]  = b_din;
    assign a_dout    = p_dout[0];
    assign b_dout    = p_dout[1];
    assign a_valid   = p_valid[0];
    assign b_valid   = p_valid[1];

`ifdef RAM_DP_BE_PARITY_EN
    logic [1:0] p_inj;
    logic [1:0] p_perr;
    assign p_inj  = {b_perr_inject, a_perr_inject};
    assign a_perr = p_perr[0];
    assign b_perr = p_perr[1];
`endif

    for (genvar p = 0; p < 2; p++) begin : g_req
        assign wmask[p]  = (!init_busy && p_en[p]) ? p_we[p] : '0;
        assign rd_req[p] = !init_busy && p_en[p] && (p_we[p] == '0);
    end

    // ---------------- storage array ----------------
    // Port B is applied before port A, so when both enable the same byte of
    // the same word, A's non-blocking update lands last and wins.
    always_ff @(posedge clk) begin
        if (init_busy) begin
            mem[clr_ptr] <= CLEAR_VALUE;
`ifdef RAM_DP_BE_PARITY_EN
            mem_par[clr_ptr] <= byte_par(CLEAR_VALUE);
`endif
        end else begin
            for (int p = 1; p >= 0; p--) begin
                for (int i = 0; i < NB; i++) begin
                    if (wmask[p][i]) begin
                        mem[p_addr[p]][i*8 +: 8] <= p_din[p][i*8 +: 8];
`ifdef RAM_DP_BE_PARITY_EN
                        mem_par[p_addr[p]][i] <= (^p_din[p][i*8 +: 8]) ^ p_inj[p];
`endif
                    end
                end
            end
        end
    end

    // ---------------- read pipelines ----------------
    for (genvar p = 0; p < 2; p++) begin : g_port
        logic                  s1_v;
        logic [DATA_WIDTH-1:0] s1_d;
        logic                  s1_err;

        // Stage 1 samples the array at the request edge: read-first against
        // any write to the same word in that cycle.
`ifdef RAM_DP_BE_PARITY_EN
        logic [NB-1:0] s1_p;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_v <= 1'b0;
                s1_d <= '0;
                s1_p <= '0;
            end else begin
                s1_v <= rd_req[p];
                if (rd_req[p]) begin
                    s1_d <= mem[p_addr[p]];
                    s1_p <= mem_par[p_addr[p]];
                end
            end
        end
        assign s1_err = s1_v && (s1_p != byte_par(s1_d));
`else
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_v <= 1'b0;
                s1_d <= '0;
            end else begin
                s1_v <= rd_req[p];
                if (rd_req[p]) s1_d <= mem[p_addr[p]];
            end
        end
        assign s1_err = 1'b0;
`endif

        if (READ_LATENCY == 2) begin : g_lat2
            logic                  s2_v;
            logic [DATA_WIDTH-1:0] s2_d;
            logic                  s2_err;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_v   <= 1'b0;
                    s2_d   <= '0;
                    s2_err <= 1'b0;
                end else begin
                    s2_v   <= s1_v;
                    s2_err <= s1_err;
                    if (s1_v) s2_d <= s1_d;
                end
            end
            assign p_dout[p]  = s2_d;
            assign p_valid[p] = s2_v;
`ifdef RAM_DP_BE_PARITY_EN
            assign p_perr[p]  = s2_err;
`endif
        end else begin : g_lat1
            assign p_dout[p]  = s1_d;
            assign p_valid[p] = s1_v;
`ifdef RAM_DP_BE_PARITY_EN
            assign p_perr[p]  = s1_err;
`endif
        end

`ifndef RAM_DP_BE_PARITY_EN
        logic unused_err;
        assign unused_err = s1_err;
`endif
    end

    // ---------------- collision flag ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collision <= 1'b0;
        end else begin
            collision <= !init_busy && a_en && b_en && (a_addr == b_addr)
                         && ((a_we | b_we) != '0);
        end
    end

endmodule

// File: tb/tb_ram_dp_be.sv
// tb/tb_ram_dp_be.sv - self-checking bench for ram_dp_be against a behavioural word/byte model

module tb_ram_dp_be;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int LAT   = 1;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          init_busy;
    logic          a_en, b_en;
    logic [NB-1:0] a_we, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_din, b_din, a_dout, b_dout;
    logic          a_valid, b_valid, collision;
    logic          a_perr_inject, b_perr_inject, a_perr, b_perr;

    ram_dp_be #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .READ_LATENCY(LAT),
        .CLEAR_VALUE (16'h0000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .init_busy(init_busy),
        .a_en     (a_en),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_din    (a_din),
        .a_dout   (a_dout),
        .a_valid  (a_valid),
        .b_en     (b_en),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_din    (b_din),
        .b_dout   (b_dout),
        .b_valid  (b_valid),
`ifdef RAM_DP_BE_PARITY_EN
        .a_perr_inject(a_perr_inject),
        .b_perr_inject(b_perr_inject),
        .a_perr   (a_perr),
        .b_perr   (b_perr),
`endif
        .collision(collision)
    );

`ifndef RAM_DP_BE_PARITY_EN
    assign a_perr = 1'b0;
    assign b_perr = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: word array, stored parity, completion queue per port.
    logic [DW-1:0] mdl  [DEPTH];
    logic [NB-1:0] mpar [DEPTH];
    int            busy_cnt;
    logic          pv [2][LAT];
    logic [DW-1:0] pd [2][LAT];
    logic          pe [2][LAT];
    logic [DW-1:0] exp_dout [2];
    logic          exp_valid [2];
    logic          exp_perr [2];
    logic          exp_coll;
    logic          exp_busy;

    function automatic logic [NB-1:0] bpar(input logic [DW-1:0] d);
        return {^d[15:8], ^d[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        chk("init_busy", {31'b0, init_busy}, {31'b0, exp_busy});
        chk("a_valid",   {31'b0, a_valid},   {31'b0, exp_valid[0]});
        chk("b_valid",   {31'b0, b_valid},   {31'b0, exp_valid[1]});
        chk("a_dout",    {16'b0, a_dout},    {16'b0, exp_dout[0]});
        chk("b_dout",    {16'b0, b_dout},    {16'b0, exp_dout[1]});
        chk("collision", {31'b0, collision}, {31'b0, exp_coll});
`ifdef RAM_DP_BE_PARITY_EN
        chk("a_perr",    {31'b0, a_perr},    {31'b0, exp_perr[0]});
        chk("b_perr",    {31'b0, b_perr},    {31'b0, exp_perr[1]});
`endif
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mdl[i]  = '0;
            mpar[i] = bpar(16'h0000);
        end
        busy_cnt = DEPTH;
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < LAT; s++) begin
                pv[p][s] = 1'b0; pd[p][s] = '0; pe[p][s] = 1'b0;
            end
            exp_dout[p] = '0; exp_valid[p] = 1'b0; exp_perr[p] = 1'b0;
        end
        exp_coll = 1'b0;
        exp_busy = 1'b1;
    endtask

    // One clock: evaluate the request against the model, advance the clock,
    // then compare every output.
    task automatic tick();
        logic          en [2];
        logic [NB-1:0] we [2];
        logic [AW-1:0] ad [2];
        logic [DW-1:0] dn [2];
        logic          inj [2];
        logic          rv [2];
        logic [DW-1:0] rd [2];
        logic          re [2];
        logic          coll;
        logic [DW-1:0] nw;
        logic [NB-1:0] np;
        en[0] = a_en; we[0] = a_we; ad[0] = a_addr; dn[0] = a_din; inj[0] = a_perr_inject;
        en[1] = b_en; we[1] = b_we; ad[1] = b_addr; dn[1] = b_din; inj[1] = b_perr_inject;
        coll = 1'b0;
        for (int p = 0; p < 2; p++) begin rv[p] = 1'b0; rd[p] = '0; re[p] = 1'b0; end
        if (busy_cnt > 0) begin
            busy_cnt--;
        end else begin
            for (int p = 0; p < 2; p++) begin
                rv[p] = en[p] && (we[p] == '0);
                rd[p] = mdl[ad[p]];
                re[p] = rv[p] && (mpar[ad[p]] != bpar(mdl[ad[p]]));
            end
            coll = en[0] && en[1] && (ad[0] == ad[1]) && ((we[0] | we[1]) != '0);
            for (int p = 0; p < 2; p++) begin
                if (!en[p]) continue;
                nw = mdl[ad[p]];
                np = mpar[ad[p]];
                for (int i = 0; i < NB; i++) begin
                    // A byte is taken from this port unless A also enables it at the same word.
                    if (we[p][i] && !(p == 1 && en[0] && ad[0] == ad[1] && we[0][i])) begin
                        nw[i*8 +: 8] = dn[p][i*8 +: 8];
                        np[i]        = (^dn[p][i*8 +: 8]) ^ inj[p];
                    end
                end
                mdl[ad[p]]  = nw;
                mpar[ad[p]] = np;
            end
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            for (int s = LAT - 1; s > 0; s--) begin
                pv[p][s] = pv[p][s-1]; pd[p][s] = pd[p][s-1]; pe[p][s] = pe[p][s-1];
            end
            pv[p][0] = rv[p]; pd[p][0] = rd[p]; pe[p][0] = re[p];
            exp_valid[p] = pv[p][LAT-1];
            exp_perr[p]  = pe[p][LAT-1];
            if (pv[p][LAT-1]) exp_dout[p] = pd[p][LAT-1];
        end
        exp_coll = coll;
        exp_busy = (busy_cnt > 0);
        check_all();
    endtask

    task automatic idle();
        a_en = 0; a_we = '0; a_perr_inject = 0;
        b_en = 0; b_we = '0; b_perr_inject = 0;
    endtask

    task automatic set_a(input logic en, input logic [NB-1:0] we, input logic [AW-1:0] ad, input logic [DW-1:0] dn);
        a_en = en; a_we = we; a_addr = ad; a_din = dn;
    endtask

    task automatic set_b(input logic en, input logic [NB-1:0] we, input logic [AW-1:0] ad, input logic [DW-1:0] dn);
        b_en = en; b_we = we; b_addr = ad; b_din = dn;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_wait(input string tag);
        int n;
        n = 0;
        while (init_busy && n < 40) begin
            tick();
            n++;
        end
        chk(tag, n, DEPTH);
    endtask

    task automatic drain();
        idle();
        repeat (LAT) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        a_addr = '0; a_din = '0; b_addr = '0; b_din = '0;
        idle();
        #3;
        reset_pulse();

        // Requests during clear must be ignored.
        set_a(1, 2'b11, 4'd1, 16'hFFFF);
        set_b(1, 2'b00, 4'd1, 16'h0000);
        clear_wait("clear_len");
        idle();

        // Every address reads back zero on both ports, pipelined.
        for (int i = 0; i < DEPTH; i++) begin
            set_a(1, 2'b00, AW'(i), 16'h0);
            set_b(1, 2'b00, AW'(DEPTH - 1 - i), 16'h0);
            tick();
        end
        drain();

        // Byte-enable read-modify-write.
        set_a(1, 2'b11, 4'd3, 16'hBEEF); tick();
        set_a(1, 2'b10, 4'd3, 16'h12AB); tick();
        set_a(1, 2'b00, 4'd3, 16'h0000); tick();
        idle();
        repeat (LAT - 1) tick();
        chk("rmw_data",  {16'b0, a_dout}, 32'h12EF);
        chk("rmw_valid", {31'b0, a_valid}, 32'h1);

        // Both ports write the same word.
        set_a(1, 2'b11, 4'd5, 16'hAAAA);
        set_b(1, 2'b01, 4'd5, 16'h5555);
        tick();
        chk("coll_ww", {31'b0, collision}, 32'h1);
        idle(); tick();
        chk("coll_ww_end", {31'b0, collision}, 32'h0);
        set_b(1, 2'b00, 4'd5, 16'h0); tick(); idle();
        repeat (LAT - 1) tick();
        chk("ww_data", {16'b0, b_dout}, 32'hAAAA);

        // Write on A with a read on B at the same word is read-first.
        set_a(1, 2'b11, 4'd7, 16'h1111); tick();
        set_a(1, 2'b11, 4'd7, 16'h2222);
        set_b(1, 2'b00, 4'd7, 16'h0);
        tick();
        chk("coll_rw", {31'b0, collision}, 32'h1);
        idle();
        repeat (LAT - 1) tick();
        chk("rw_old", {16'b0, b_dout}, 32'h1111);
        set_b(1, 2'b00, 4'd7, 16'h0); tick(); idle();
        repeat (LAT - 1) tick();
        chk("rw_new", {16'b0, b_dout}, 32'h2222);

        // Both read the same word: no collision.
        set_a(1, 2'b00, 4'd7, 16'h0);
        set_b(1, 2'b00, 4'd7, 16'h0);
        tick();
        chk("coll_rr", {31'b0, collision}, 32'h0);
        drain();

        // Reset in the middle of the clear, with a write pending.
        reset_pulse();
        repeat (9) tick();
        set_a(1, 2'b11, 4'd4, 16'h9999);
        reset_pulse();
        set_a(1, 2'b11, 4'd4, 16'h9999);
        clear_wait("reclear_len");
        set_a(1, 2'b00, 4'd4, 16'h0); tick();
        set_a(1, 2'b00, 4'd3, 16'h0); tick();
        idle();
        repeat (LAT - 1) tick();
        chk("dropped_wr", {16'b0, a_dout}, 32'h0000);
        drain();

`ifdef RAM_DP_BE_PARITY_EN
        set_a(1, 2'b01, 4'd2, 16'h00FF); a_perr_inject = 1; tick();
        a_perr_inject = 0;
        set_a(1, 2'b00, 4'd2, 16'h0); tick(); idle();
        repeat (LAT - 1) tick();
        chk("perr_inj", {31'b0, a_perr}, 32'h1);
        set_a(1, 2'b01, 4'd2, 16'h00FF); tick();
        set_a(1, 2'b00, 4'd2, 16'h0); tick(); idle();
        repeat (LAT - 1) tick();
        chk("perr_clean", {31'b0, a_perr}, 32'h0);
`endif

        // Random traffic over a small address window to provoke conflicts.
        for (int n = 0; n < 400; n++) begin
            a_en   = $urandom_range(0, 3) != 0;
            b_en   = $urandom_range(0, 3) != 0;
            a_we   = ($urandom_range(0, 1) != 0) ? 2'b00 : NB'($urandom_range(1, 3));
            b_we   = ($urandom_range(0, 1) != 0) ? 2'b00 : NB'($urandom_range(1, 3));
            a_addr = AW'($urandom_range(0, 3));
            b_addr = AW'($urandom_range(0, 3));
            a_din  = DW'($urandom);
            b_din  = DW'($urandom);
`ifdef RAM_DP_BE_PARITY_EN
            a_perr_inject = $urandom_range(0, 7) == 0;
            b_perr_inject = $urandom_range(0, 7) == 0;
`endif
            tick();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
